stoch_signed_decoder: RTL and testbench

Converts a signed stochastic bitstream pair (xp, xn) into a two's-complement binary estimate. It does this by counting (xp - xn) over a window of 2^WINDOW_BITS cycles. It sits at the output end of stochastic datapaths such as the L2 norm, dot product and square root blocks, which produce (yp, yn) pairs, and hands binary results to control/readout logic. It supports one-shot windows (start pulse) and back-to-back windows (cont).

---
 rtl/stoch_pkg.sv | 15 +
 rtl/stoch_signed_accum.sv | 26 ++
 rtl/stoch_signed_decoder.sv | 82 ++++++++
 tb/tb_stoch_signed_decoder.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/stoch_pkg.sv
// Shared types and helpers for signed stochastic bitstream blocks.
package stoch_pkg;

    typedef enum logic {DEC_IDLE, DEC_ACCUM} stoch_dec_state_t;

    // Signed contribution of one (xp, xn) sample; both high cancel.
    function automatic logic signed [1:0] stream_delta(input logic xp, input logic xn);
        case ({xp, xn})
            2'b10:   return 2'sb01;
            2'b01:   return 2'sb11;
            default: return 2'sb00;
        endcase
    endfunction

endpackage

// File: rtl/stoch_signed_accum.sv
// Signed up/down accumulator stepped by a -1/0/+1 delta, with sync clear and enable.
module stoch_signed_accum #(
    parameter int WIDTH = 10
) (
    input  logic                    CLK,
    input  logic                    nRST,
    input  logic                    clr,
    input  logic                    en,
    input  logic signed [1:0]       delta,
    output logic signed [WIDTH-1:0] acc,
    output logic signed [WIDTH-1:0] acc_next
);

    assign acc_next = acc + {{(WIDTH-2){delta[1]}}, delta};

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc_next;
        end
    end

endmodule

// File: rtl/stoch_signed_decoder.sv
// Counts (xp - xn) over 2^WINDOW_BITS samples and reports a signed estimate per window.
//   state     | meaning
//   DEC_IDLE  | waiting for start, streams ignored
//   DEC_ACCUM | sampling streams, one sample per edge
module stoch_signed_decoder
    import stoch_pkg::*;
#(
    parameter  int WINDOW_BITS = 8,
    localparam int OUT_WIDTH   = WINDOW_BITS + 2
) (
    input  logic                        CLK,
    input  logic                        nRST,
    input  logic                        start,
    input  logic                        cont,
    input  logic                        xp,
    input  logic                        xn,
    output logic                        busy,
    output logic                        valid,
    output logic signed [OUT_WIDTH-1:0] value
);

    localparam logic [WINDOW_BITS-1:0] CNT_ONE = WINDOW_BITS'(1);

    stoch_dec_state_t               state;
    logic [WINDOW_BITS-1:0]         cnt;
    logic                           last_sample;
    logic                           acc_clr;
    logic                           acc_en;
    logic signed [1:0]              delta;
    logic signed [OUT_WIDTH-1:0]    acc;
    logic signed [OUT_WIDTH-1:0]    acc_next;

    assign delta       = stream_delta(xp, xn);
    assign last_sample = (state == DEC_ACCUM) && (cnt == '1);
    assign acc_en      = (state == DEC_ACCUM);
    // Clearing on the last sample lets a continued window start from zero with no gap.
    assign acc_clr     = ((state == DEC_IDLE) && start) || last_sample;
    assign busy        = (state == DEC_ACCUM);

    stoch_signed_accum #(
        .WIDTH (OUT_WIDTH)
    ) u_accum (
        .CLK      (CLK),
        .nRST     (nRST),
        .clr      (acc_clr),
        .en       (acc_en),
        .delta    (delta),
        .acc      (acc),
        .acc_next (acc_next)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= DEC_IDLE;
            cnt   <= '0;
            valid <= 1'b0;
            value <= '0;
        end else begin
            valid <= 1'b0;
            case (state)
                DEC_IDLE: begin
                    if (start) begin
                        state <= DEC_ACCUM;
                        cnt   <= '0;
                    end
                end
                DEC_ACCUM: begin
                    cnt <= cnt + CNT_ONE;
                    if (cnt == '1) begin
                        value <= acc_next;
                        valid <= 1'b1;
                        if (!cont) begin
                            state <= DEC_IDLE;
                        end
                    end
                end
                default: state <= DEC_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stoch_signed_decoder.sv
// Bench for stoch_signed_decoder (WINDOW_BITS=4): window-level reference model plus directed literals.
module tb_stoch_signed_decoder;

    localparam int WB = 4;
    localparam int N  = 16;
    localparam int OW = 6;

    logic          CLK   = 1'b0;
    logic          nRST  = 1'b0;
    logic          start = 1'b0;
    logic          cont  = 1'b0;
    logic          xp    = 1'b0;
    logic          xn    = 1'b0;
    logic          busy;
    logic          valid;
    logic [OW-1:0] value;

    stoch_signed_decoder #(.WINDOW_BITS(WB)) dut (
        .CLK   (CLK),
        .nRST  (nRST),
        .start (start),
        .cont  (cont),
        .xp    (xp),
        .xn    (xn),
        .busy  (busy),
        .valid (valid),
        .value (value)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: collects the window's sample deltas and sums them when N are in.
    bit m_busy  = 1'b0;
    bit m_valid = 1'b0;
    int m_value = 0;
    int m_q[$];

    always @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            m_busy  = 1'b0;
            m_valid = 1'b0;
            m_value = 0;
            m_q.delete();
        end else begin
            m_valid = 1'b0;
            if (!m_busy) begin
                if (start) begin
                    m_busy = 1'b1;
                    m_q.delete();
                end
            end else begin
                m_q.push_back(int'(xp) - int'(xn));
                if (m_q.size() == N) begin
                    m_value = m_q.sum();
                    m_valid = 1'b1;
                    m_q.delete();
                    m_busy  = cont;
                end
            end
        end
    end

    always @(negedge CLK) begin
        if (nRST) begin
            check("busy",  int'(busy),  int'(m_busy));
            check("valid", int'(valid), int'(m_valid));
            check("value", int'($signed(value)), m_value);
        end
    end

    task automatic step(input bit s, input bit c, input bit p, input bit n);
        start = s;
        cont  = c;
        xp    = p;
        xn    = n;
        @(posedge CLK);
        #1;
    endtask

    function automatic bit [1:0] pat(input int id, input int i);
        case (id)
            0:       return 2'b10;
            1:       return 2'b01;
            2:       return 2'b11;
            3:       return {(i % 2) == 0, 1'b0};
            default: return {(i % 2) == 0, i < 4};
        endcase
    endfunction

    task automatic run_window(input int id, input int expv, input string nm);
        bit [1:0] pn;
        int busy_cnt;
        int vcnt;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        busy_cnt = int'(busy);
        vcnt = 0;
        for (int i = 0; i < N; i++) begin
            pn = pat(id, i);
            step(1'b0, 1'b0, pn[1], pn[0]);
            if (i < N - 1) begin
                busy_cnt += int'(busy);
                vcnt += int'(valid);
            end
        end
        check({nm, "_early_valid"}, vcnt, 0);
        check({nm, "_valid"}, int'(valid), 1);
        check({nm, "_value"}, int'($signed(value)), expv);
        check({nm, "_busy_cycles"}, busy_cnt, N);
        check({nm, "_busy_after"}, int'(busy), 0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check({nm, "_valid_drop"}, int'(valid), 0);
        check({nm, "_value_hold"}, int'($signed(value)), expv);
    endtask

    initial begin
        int vcnt;
        int last;
        bit c;

        repeat (3) @(posedge CLK);
        #1;
        check("rst_busy",  int'(busy),  0);
        check("rst_valid", int'(valid), 0);
        check("rst_value", int'($signed(value)), 0);
        nRST = 1'b1;
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("idle_busy", int'(busy), 0);

        run_window(0,  16, "pos_full");
        run_window(1, -16, "neg_full");
        check("neg_bits", int'(value), 6'b110000);
        run_window(2,   0, "cancel");
        run_window(3,   8, "even_xp");
        run_window(4,   4, "alt_mix");

        // Back-to-back windows, cont dropped inside the third one.
        step(1'b1, 1'b1, 1'b1, 1'b0);
        vcnt = 0;
        last = -1;
        for (int i = 0; i < 3 * N + 6; i++) begin
            c = (i < 2 * N + 5);
            step(1'b0, c, 1'b1, 1'b0);
            if (valid) begin
                vcnt++;
                check("cont_value", int'($signed(value)), 16);
                if (last >= 0) check("cont_period", i - last, N);
                last = i;
            end
        end
        check("cont_count", vcnt, 3);
        check("cont_busy_end", int'(busy), 0);

        // Asynchronous reset in the middle of sample 7.
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
        xp = 1'b1;
        #2 nRST = 1'b0;
        #1;
        check("midrst_busy",  int'(busy),  0);
        check("midrst_valid", int'(valid), 0);
        check("midrst_value", int'($signed(value)), 0);
        #2 nRST = 1'b1;
        @(posedge CLK);
        #1;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0);
            check("postrst_idle", int'(busy), 0);
        end
        run_window(1, -16, "postrst");

        // start pulses while busy, including on the last sample.
        step(1'b1, 1'b0, 1'b0, 1'b0);
        vcnt = 0;
        for (int i = 0; i < N; i++) begin
            step((i == 3) || (i == 15), 1'b0, 1'b1, 1'b0);
            vcnt += int'(valid);
        end
        check("busystart_value", int'($signed(value)), 16);
        check("busystart_valids", vcnt, 1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("busystart_idle", int'(busy), 0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("busystart_novalid", int'(valid), 0);

        // Randomized traffic with occasional asynchronous resets.
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 199) == 0) begin
                #2 nRST = 1'b0;
                #1 nRST = 1'b1;
            end
        end
        step(1'b0, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
